// File: rtl/pit_bus_master.sv
// rtl/pit_bus_master.sv - 8253 PIT bus initiator: program and latch-read sequencer
//
// Turns a one-cycle command into the 8253 control-word / count-byte bus cycles.
// Optional feature macro: PIT_READBACK_EN (latch-and-read support; read path
// is not built when undefined, OP=1 is then rejected).
//
// Ports:
//   CLK, RESET_              clock, asynchronous active-low reset
//   REQ, OP, CHAN, RW,       command request and fields, captured on acceptance
//   MODE, BCD, COUNT
//   BUSY, DONE, ERR          status: in progress, completion pulse, reject pulse
//   RDATA                    latch-read result, updated at completion
//   CS_, RD_, WR_, A1, A0    8253 bus control and address (strobes active low)
//   DOUT, DOE                write data and its pad drive enable
//   DIN                      read data from the bus
`timescale 1ns/1ps

module pit_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic        CLK,
  input  logic        RESET_,
  input  logic        REQ,
  input  logic        OP,
  input  logic [1:0]  CHAN,
  input  logic [1:0]  RW,
  input  logic [2:0]  MODE,
  input  logic        BCD,
  input  logic [15:0] COUNT,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic        CS_,
  output logic        RD_,
  output logic        WR_,
  output logic        A1,
  output logic        A0,
  output logic [7:0]  DOUT,
  output logic        DOE,
  input  logic [7:0]  DIN
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  localparam logic [3:0] L_SETUP_LAST  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] L_STROBE_LAST = 4'(STROBE_CYC - 1);
  localparam logic [3:0] L_HOLD_LAST   = 4'(HOLD_CYC - 1);

  state_t      r_state, w_state_nx;
  logic [3:0]  r_phase, w_phase_nx;
  logic [1:0]  r_byte, w_byte_nx;

  logic [1:0]  r_chan, r_rw;
  logic [2:0]  r_mode;
  logic        r_bcd;
  logic [15:0] r_count;

  logic        w_req_bad, w_accept, w_done_nx, w_err_nx, w_strobe_end;
  logic [1:0]  w_last_byte;
  logic [1:0]  w_chan_c, w_rw_c;
  logic [2:0]  w_mode_c;
  logic        w_bcd_c, w_op_c;
  logic [15:0] w_count_c;
  logic        w_active_nx, w_read_nx;
  logic [7:0]  w_ctrl_word, w_data_nx;

`ifdef PIT_READBACK_EN
  logic        r_op;
  logic [7:0]  r_rd_lo, r_rd_hi;

  assign w_req_bad = (CHAN == 2'd3) || (RW == 2'b00);
  assign w_op_c    = w_accept ? OP : r_op;
  assign w_read_nx = w_op_c && (w_byte_nx != 2'd0);
`else
  assign w_req_bad = (CHAN == 2'd3) || (RW == 2'b00) || OP;
  assign w_op_c    = 1'b0;
  assign w_read_nx = 1'b0;
  wire   w_unused  = ^{DIN, w_strobe_end};
`endif

  // Fields seen by the output decode: the live inputs on the accepting edge,
  // the captured copies afterwards.
  assign w_chan_c  = w_accept ? CHAN  : r_chan;
  assign w_rw_c    = w_accept ? RW    : r_rw;
  assign w_mode_c  = w_accept ? MODE  : r_mode;
  assign w_bcd_c   = w_accept ? BCD   : r_bcd;
  assign w_count_c = w_accept ? COUNT : r_count;

  // Control word plus one count byte, or two for LSB-then-MSB.
  assign w_last_byte = (r_rw == 2'b11) ? 2'd2 : 2'd1;

  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      r_state <= S_IDLE;
      r_phase <= 4'd0;
      r_byte  <= 2'd0;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
      r_byte  <= w_byte_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_phase_nx   = r_phase;
    w_byte_nx    = r_byte;
    w_accept     = 1'b0;
    w_done_nx    = 1'b0;
    w_err_nx     = 1'b0;
    w_strobe_end = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (REQ) begin
          if (w_req_bad) begin
            w_done_nx = 1'b1;
            w_err_nx  = 1'b1;
          end else begin
            w_accept   = 1'b1;
            w_state_nx = S_SETUP;
            w_phase_nx = 4'd0;
            w_byte_nx  = 2'd0;
          end
        end
      end
      S_SETUP: begin
        if (r_phase == L_SETUP_LAST) begin
          w_state_nx = S_STROBE;
          w_phase_nx = 4'd0;
        end else begin
          w_phase_nx = r_phase + 4'd1;
        end
      end
      S_STROBE: begin
        if (r_phase == L_STROBE_LAST) begin
          w_state_nx   = S_HOLD;
          w_phase_nx   = 4'd0;
          w_strobe_end = 1'b1;
        end else begin
          w_phase_nx = r_phase + 4'd1;
        end
      end
      S_HOLD: begin
        if (r_phase == L_HOLD_LAST) begin
          w_phase_nx = 4'd0;
          if (r_byte == w_last_byte) begin
            w_state_nx = S_IDLE;
            w_done_nx  = 1'b1;
          end else begin
            w_state_nx = S_GAP;
            w_byte_nx  = r_byte + 2'd1;
          end
        end else begin
          w_phase_nx = r_phase + 4'd1;
        end
      end
      S_GAP: begin
        w_state_nx = S_SETUP;
        w_phase_nx = 4'd0;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      r_chan  <= 2'd0;
      r_rw    <= 2'd0;
      r_mode  <= 3'd0;
      r_bcd   <= 1'b0;
      r_count <= 16'h0000;
    end else if (w_accept) begin
      r_chan  <= CHAN;
      r_rw    <= RW;
      r_mode  <= MODE;
      r_bcd   <= BCD;
      r_count <= COUNT;
    end
  end

  // Latch command is the control word with RW=00 (counter latch).
  assign w_ctrl_word = w_op_c ? {w_chan_c, 6'b000000}
                              : {w_chan_c, w_rw_c, w_mode_c, w_bcd_c};
  assign w_active_nx = (w_state_nx == S_SETUP) || (w_state_nx == S_STROBE) ||
                       (w_state_nx == S_HOLD);
  // Byte 1 is the MSB only for MSB-only transfers; byte 2 is always the MSB.
  assign w_data_nx   = (w_byte_nx == 2'd0) ? w_ctrl_word :
                       ((w_byte_nx == 2'd2) || (w_rw_c == 2'b10)) ? w_count_c[15:8]
                                                                 : w_count_c[7:0];

  // Outputs are registered from the next-state decode so they change together
  // with the state, glitch-free.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      CS_  <= 1'b1;
      WR_  <= 1'b1;
      A1   <= 1'b0;
      A0   <= 1'b0;
      DOUT <= 8'h00;
      DOE  <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      ERR  <= 1'b0;
    end else begin
      CS_      <= ~w_active_nx;
      WR_      <= ~((w_state_nx == S_STROBE) && !w_read_nx);
      {A1, A0} <= w_active_nx ? ((w_byte_nx == 2'd0) ? 2'b11 : w_chan_c) : 2'b00;
      DOUT     <= (w_active_nx && !w_read_nx) ? w_data_nx : 8'h00;
      DOE      <= w_active_nx && !w_read_nx;
      BUSY     <= (w_state_nx != S_IDLE);
      DONE     <= w_done_nx;
      ERR      <= w_err_nx;
    end
  end

`ifdef PIT_READBACK_EN
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      RD_     <= 1'b1;
      RDATA   <= 16'h0000;
      r_op    <= 1'b0;
      r_rd_lo <= 8'h00;
      r_rd_hi <= 8'h00;
    end else begin
      RD_ <= ~((w_state_nx == S_STROBE) && w_read_nx);
      if (w_accept) begin
        r_op    <= OP;
        r_rd_lo <= 8'h00;
        r_rd_hi <= 8'h00;
      end else if (w_strobe_end && r_op && (r_byte != 2'd0)) begin
        if ((r_byte == 2'd2) || (r_rw == 2'b10)) r_rd_hi <= DIN;
        else                                     r_rd_lo <= DIN;
      end
      // Only a completed latch-read replaces the result; rejects leave it.
      if (w_done_nx && !w_err_nx && r_op) RDATA <= {r_rd_hi, r_rd_lo};
    end
  end
`else
  assign RD_   = 1'b1;
  assign RDATA = 16'h0000;
`endif

endmodule

// File: tb/tb_pit_bus_master.sv
// tb/tb_pit_bus_master.sv - self-checking bench for pit_bus_master
`timescale 1ns/1ps

module tb_pit_bus_master;

  localparam int S = 1;
  localparam int T = 2;
  localparam int H = 1;
`ifdef PIT_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_ = 1'b0;
  logic        REQ = 1'b0, OP = 1'b0, BCD = 1'b0;
  logic [1:0]  CHAN = 2'd0, RW = 2'd0;
  logic [2:0]  MODE = 3'd0;
  logic [15:0] COUNT = 16'h0000;
  logic        BUSY, DONE, ERR, CS_, RD_, WR_, A1, A0, DOE;
  logic [15:0] RDATA;
  logic [7:0]  DOUT, DIN;

  pit_bus_master #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
    .CLK(CLK), .RESET_(RESET_), .REQ(REQ), .OP(OP), .CHAN(CHAN), .RW(RW),
    .MODE(MODE), .BCD(BCD), .COUNT(COUNT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .RDATA(RDATA), .CS_(CS_), .RD_(RD_), .WR_(WR_), .A1(A1), .A0(A0),
    .DOUT(DOUT), .DOE(DOE), .DIN(DIN)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        busy, done, err, cs_n, rd_n, wr_n;
    logic [1:0]  addr;
    logic [7:0]  dout;
    logic        doe;
    logic [15:0] rdata;
  } obs_t;

  obs_t        exp_q[$];
  logic [15:0] cur_rdata = 16'h0000;
  logic [15:0] m_rdata = 16'h0000;
  int          m_rd_ptr = 0;
  int          errors = 0;
  int          checks = 0;

  // Bus monitor: observations only, compared against literals later.
  int          busy_cnt = 0, done_cnt = 0, err_cnt = 0, cs_cnt = 0, wcnt = 0, rcnt = 0;
  logic [9:0]  wlog[64];
  logic [1:0]  rlog[8];
  logic        prev_wr = 1'b1, prev_rd = 1'b1;
  logic [7:0]  rd_vals[2];

  always @(negedge CLK) begin
    if (BUSY) busy_cnt++;
    if (DONE) done_cnt++;
    if (ERR) err_cnt++;
    if (!CS_) cs_cnt++;
    if (!WR_ && prev_wr) begin wlog[wcnt % 64] = {A1, A0, DOUT}; wcnt++; end
    if (!RD_ && prev_rd) begin rlog[rcnt % 8] = {A1, A0}; rcnt++; end
    prev_wr = WR_;
    prev_rd = RD_;
  end

  // The n-th read strobe (n = rcnt) is answered with rd_vals[n-1].
  assign DIN = (rcnt % 2 == 1) ? rd_vals[0] : rd_vals[1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t idle_obs(input logic [15:0] rd);
    obs_t e;
    e = '0;
    e.cs_n = 1'b1; e.rd_n = 1'b1; e.wr_n = 1'b1;
    e.rdata = rd;
    return e;
  endfunction

  // Per-cycle compare against the model trace (idle when the trace is empty).
  task automatic cycle();
    obs_t a, e, m;
    @(negedge CLK);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = idle_obs(cur_rdata);
    cur_rdata = e.rdata;
    a = {BUSY, DONE, ERR, CS_, RD_, WR_, A1, A0, DOUT, DOE, RDATA};
    m = '1;
    if (e.cs_n) begin m.addr = '0; m.dout = '0; end
    if (!e.doe) m.dout = '0;
    checks++;
    if ((a & m) !== (e & m)) begin
      errors++;
      $display("FAIL trace t=%0t: got %h expected %h", $time, a, e);
    end
    @(posedge CLK);
    #1;
  endtask

  // Model: list the bus bytes the command needs, then expand each byte into
  // setup/strobe/hold cycles with one idle gap between bytes, then DONE.
  task automatic push_cmd(input logic op, input logic [1:0] chan, input logic [1:0] rw,
                          input logic [2:0] mode, input logic bcd, input logic [15:0] count,
                          output int pushed);
    logic [1:0]  b_addr[3];
    logic [7:0]  b_data[3];
    logic        b_rd[3];
    logic [15:0] new_rd;
    int          n;
    obs_t        e;
    pushed = 0;
    if (chan == 2'd3 || rw == 2'b00 || (op && !RB)) begin
      e = idle_obs(m_rdata);
      e.done = 1'b1; e.err = 1'b1;
      exp_q.push_back(e);
      pushed = 1;
      return;
    end
    new_rd = 16'h0000;
    b_addr[0] = 2'b11; b_rd[0] = 1'b0;
    b_data[0] = op ? {chan, 6'b000000} : {chan, rw, mode, bcd};
    n = 1;
    if (rw[0]) begin
      b_addr[n] = chan; b_rd[n] = op; b_data[n] = count[7:0];
      if (op) begin new_rd[7:0] = rd_vals[m_rd_ptr % 2]; m_rd_ptr++; end
      n++;
    end
    if (rw[1]) begin
      b_addr[n] = chan; b_rd[n] = op; b_data[n] = count[15:8];
      if (op) begin new_rd[15:8] = rd_vals[m_rd_ptr % 2]; m_rd_ptr++; end
      n++;
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        e = idle_obs(m_rdata); e.busy = 1'b1;
        exp_q.push_back(e); pushed++;
      end
      for (int c = 0; c < S + T + H; c++) begin
        e = idle_obs(m_rdata);
        e.busy = 1'b1; e.cs_n = 1'b0; e.addr = b_addr[i];
        e.doe = !b_rd[i];
        e.dout = b_rd[i] ? 8'h00 : b_data[i];
        if (c >= S && c < S + T) begin
          e.wr_n = b_rd[i];
          e.rd_n = !b_rd[i];
        end
        exp_q.push_back(e); pushed++;
      end
    end
    if (op) m_rdata = new_rd;
    e = idle_obs(m_rdata);
    e.done = 1'b1;
    exp_q.push_back(e); pushed++;
  endtask

  task automatic drain(input int pulse_at);
    for (int i = 0; i < 64 && exp_q.size() > 0; i++) begin
      REQ = (i == pulse_at);
      cycle();
    end
    REQ = 1'b0;
    check("drain", exp_q.size(), 0);
    cycle();
  endtask

  task automatic run(input logic op, input logic [1:0] chan, input logic [1:0] rw,
                     input logic [2:0] mode, input logic bcd, input logic [15:0] count,
                     input int pulse_at, output int pushed);
    OP = op; CHAN = chan; RW = rw; MODE = mode; BCD = bcd; COUNT = count;
    REQ = 1'b1;
    cycle();
    push_cmd(op, chan, rw, mode, bcd, count, pushed);
    REQ = 1'b0;
    CHAN = ~chan; RW = ~rw; MODE = ~mode; BCD = ~bcd; COUNT = ~count;
    drain(pulse_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, b0, d0, e0, c0, w0, r0;
    rd_vals[0] = 8'h78;
    rd_vals[1] = 8'h56;

    #12;
    check("rst_cs", CS_, 1);     check("rst_rd", RD_, 1);   check("rst_wr", WR_, 1);
    check("rst_a1", A1, 0);      check("rst_a0", A0, 0);    check("rst_dout", DOUT, 0);
    check("rst_doe", DOE, 0);    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);  check("rst_err", ERR, 0);  check("rst_rdata", RDATA, 0);
    @(posedge CLK); #1;
    RESET_ = 1'b1;
    cycle(); cycle();

    // Program CH0 mode 3 binary, LSB then MSB of 0x1234.
    b0 = busy_cnt; d0 = done_cnt; e0 = err_cnt; w0 = wcnt;
    run(1'b0, 2'd0, 2'b11, 3'd3, 1'b0, 16'h1234, -1, n);
    check("t1_model_len", n, 15);
    check("t1_busy", busy_cnt - b0, 14);
    check("t1_done", done_cnt - d0, 1);
    check("t1_err", err_cnt - e0, 0);
    check("t1_nwr", wcnt - w0, 3);
    check("t1_w0", wlog[w0 % 64], {2'b11, 8'h36});
    check("t1_w1", wlog[(w0 + 1) % 64], {2'b00, 8'h34});
    check("t1_w2", wlog[(w0 + 2) % 64], {2'b00, 8'h12});

    // Program CH2 mode 2 LSB only, with a REQ pulse mid-BUSY that must be ignored.
    b0 = busy_cnt; d0 = done_cnt; w0 = wcnt;
    run(1'b0, 2'd2, 2'b01, 3'd2, 1'b0, 16'h00FF, 3, n);
    check("t2_model_len", n, 10);
    check("t2_busy", busy_cnt - b0, 9);
    check("t2_done", done_cnt - d0, 1);
    check("t2_w0", wlog[w0 % 64], {2'b11, 8'h94});
    check("t2_w1", wlog[(w0 + 1) % 64], {2'b10, 8'hFF});

    // Program CH1 mode 0 BCD, MSB only.
    w0 = wcnt;
    run(1'b0, 2'd1, 2'b10, 3'd0, 1'b1, 16'hBEEF, -1, n);
    check("t3_w0", wlog[w0 % 64], {2'b11, 8'h61});
    check("t3_w1", wlog[(w0 + 1) % 64], {2'b01, 8'hBE});

    // Latch-read CH1, LSB then MSB.
    b0 = busy_cnt; d0 = done_cnt; e0 = err_cnt; c0 = cs_cnt; w0 = wcnt; r0 = rcnt;
    run(1'b1, 2'd1, 2'b11, 3'd0, 1'b0, 16'h0000, -1, n);
`ifdef PIT_READBACK_EN
    check("lr_busy", busy_cnt - b0, 14);
    check("lr_err", err_cnt - e0, 0);
    check("lr_w0", wlog[w0 % 64], {2'b11, 8'h40});
    check("lr_nrd", rcnt - r0, 2);
    check("lr_ra0", rlog[r0 % 8], 2'b01);
    check("lr_ra1", rlog[(r0 + 1) % 8], 2'b01);
    check("lr_rdata", RDATA, 16'h5678);
`else
    check("lr_busy", busy_cnt - b0, 0);
    check("lr_done", done_cnt - d0, 1);
    check("lr_err", err_cnt - e0, 1);
    check("lr_cs", cs_cnt - c0, 0);
`endif

    // Illegal channel, then illegal RW.
    b0 = busy_cnt; e0 = err_cnt; c0 = cs_cnt;
    run(1'b0, 2'd3, 2'b11, 3'd0, 1'b0, 16'h1111, -1, n);
    check("ill_chan_err", err_cnt - e0, 1);
    e0 = err_cnt;
    run(1'b0, 2'd0, 2'b00, 3'd0, 1'b0, 16'h2222, -1, n);
    check("ill_rw_err", err_cnt - e0, 1);
    check("ill_cs", cs_cnt - c0, 0);
    check("ill_busy", busy_cnt - b0, 0);

    // Reset during the second strobe cycle of the count LSB.
    d0 = done_cnt;
    OP = 1'b0; CHAN = 2'd0; RW = 2'b11; MODE = 3'd3; BCD = 1'b0; COUNT = 16'hABCD;
    REQ = 1'b1;
    cycle();
    push_cmd(1'b0, 2'd0, 2'b11, 3'd3, 1'b0, 16'hABCD, n);
    REQ = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    check("rst_mid_pre_wr", WR_, 0);
    RESET_ = 1'b0;
    exp_q.delete();
    m_rdata = 16'h0000;
    cur_rdata = 16'h0000;
    #1;
    check("rst_mid_wr", WR_, 1);
    check("rst_mid_cs", CS_, 1);
    check("rst_mid_doe", DOE, 0);
    check("rst_mid_busy", BUSY, 0);
    cycle(); cycle();
    RESET_ = 1'b1;
    cycle(); cycle();
    check("rst_mid_nodone", done_cnt - d0, 0);
    w0 = wcnt; d0 = done_cnt;
    run(1'b0, 2'd0, 2'b01, 3'd0, 1'b0, 16'h0042, -1, n);
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_w0", wlog[w0 % 64], {2'b11, 8'h10});
    check("post_rst_w1", wlog[(w0 + 1) % 64], {2'b00, 8'h42});

    // Back-to-back: REQ held high, second command accepted in the DONE cycle.
    d0 = done_cnt; w0 = wcnt;
    OP = 1'b0; CHAN = 2'd1; RW = 2'b11; MODE = 3'd3; BCD = 1'b0; COUNT = 16'h0102;
    REQ = 1'b1;
    cycle();
    push_cmd(1'b0, 2'd1, 2'b11, 3'd3, 1'b0, 16'h0102, n);
    CHAN = 2'd2; RW = 2'b10; MODE = 3'd1; COUNT = 16'hA5C3;
    push_cmd(1'b0, 2'd2, 2'b10, 3'd1, 1'b0, 16'hA5C3, n);
    for (int i = 0; i < 15; i++) cycle();
    REQ = 1'b0;
    drain(-1);
    check("b2b_done", done_cnt - d0, 2);
    check("b2b_nwr", wcnt - w0, 5);
    check("b2b_w0", wlog[w0 % 64], {2'b11, 8'h76});
    check("b2b_w1", wlog[(w0 + 1) % 64], {2'b01, 8'h02});
    check("b2b_w2", wlog[(w0 + 2) % 64], {2'b01, 8'h01});
    check("b2b_w3", wlog[(w0 + 3) % 64], {2'b11, 8'hA2});
    check("b2b_w4", wlog[(w0 + 4) % 64], {2'b10, 8'hA5});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
